// File: rtl/ws2812_pkg.sv
// Shared types, default 100 MHz timing and parameter helpers for the WS2812B frame sender.
package ws2812_pkg;

   typedef enum logic [1:0] {
      ST_GAP  = 2'd0,
      ST_IDLE = 2'd1,
      ST_HIGH = 2'd2,
      ST_LOW  = 2'd3
   } ws2812_state_t;

   localparam int GRB_W            = 24;
   localparam int DEF_NUM_LEDS     = 5;
   localparam int DEF_T_BIT        = 125;
   localparam int DEF_T0H          = 40;
   localparam int DEF_T1H          = 80;
   localparam int DEF_RESET_CYCLES = 30000;

   function automatic int cnt_width(input int t_bit, input int reset_cycles);
      int longest;
      longest = (t_bit > reset_cycles) ? t_bit : reset_cycles;
      return $clog2(longest + 32'sd1);
   endfunction

   function automatic int addr_width(input int num_leds);
      return (num_leds > 32'sd1) ? $clog2(num_leds) : 32'sd1;
   endfunction

   function automatic bit timing_ok(input int num_leds, input int t_bit, input int t0h,
                                    input int t1h, input int reset_cycles);
      return (num_leds >= 32'sd1) && (t0h > 32'sd0) && (t0h < t1h) &&
             (t1h < t_bit) && (reset_cycles >= 32'sd1);
   endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Emits one NZR bit per start: T1H/T0H high cycles, low for the rest of T_BIT.
// bit_done marks the final cycle of the bit so the next start follows with no dead cycle.
module ws2812_bit_encoder
   import ws2812_pkg::*;
#(
   parameter int T_BIT = DEF_T_BIT,
   parameter int T0H   = DEF_T0H,
   parameter int T1H   = DEF_T1H,
   parameter int CNT_W = cnt_width(DEF_T_BIT, DEF_RESET_CYCLES)
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic bit_in,
   output logic data_out,
   output logic bit_done
);

   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(T_BIT - 1);
   localparam logic [CNT_W-1:0] T0H_C  = CNT_W'(T0H);
   localparam logic [CNT_W-1:0] T1H_C  = CNT_W'(T1H);

   logic             active_r;
   logic             data_r;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] high_len_r;
   logic [CNT_W-1:0] cnt_inc_s;

   assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
   assign bit_done  = active_r && (cnt_r == LAST_C);
   assign data_out  = data_r;

   // Phase counter and registered pin level for the bit in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         active_r   <= 1'b0;
         data_r     <= 1'b0;
         cnt_r      <= {CNT_W{1'b0}};
         high_len_r <= {CNT_W{1'b0}};
      end else if (start) begin
         active_r   <= 1'b1;
         data_r     <= 1'b1;
         cnt_r      <= {CNT_W{1'b0}};
         high_len_r <= bit_in ? T1H_C : T0H_C;
      end else if (active_r) begin
         if (cnt_r == LAST_C) begin
            active_r <= 1'b0;
            data_r   <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
         end else begin
            cnt_r  <= cnt_inc_s;
            data_r <= (cnt_inc_s < high_len_r);
         end
      end else begin
         data_r <= 1'b0;
         cnt_r  <= {CNT_W{1'b0}};
      end
   end

endmodule

// File: rtl/ws2812_frame_sender.sv
// WS2812B strip driver: pixel memory, frame serialiser and latch gap.
// Optional WS2812_AUTO_REFRESH_EN: any accepted write marks the frame dirty and restarts it from IDLE.
module ws2812_frame_sender
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS     = DEF_NUM_LEDS,
   parameter int T_BIT        = DEF_T_BIT,
   parameter int T0H          = DEF_T0H,
   parameter int T1H          = DEF_T1H,
   parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              wr_en,
   input  logic [addr_width(NUM_LEDS)-1:0]   wr_addr,
   input  logic [23:0]                       wr_grb,
   input  logic                              go,
   output logic                              data_out,
   output logic                              ready,
   output logic                              frame_done
);

   localparam int AW    = addr_width(NUM_LEDS);
   localparam int CNT_W = cnt_width(T_BIT, RESET_CYCLES);
   localparam logic [AW:0]      NUM_LEDS_C = (AW+1)'(NUM_LEDS);
   localparam logic [AW-1:0]    LAST_PIX_C = AW'(NUM_LEDS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST_C = CNT_W'(RESET_CYCLES - 1);

   if (!timing_ok(NUM_LEDS, T_BIT, T0H, T1H, RESET_CYCLES)) begin : g_param_check
      $error("ws2812_frame_sender: illegal NUM_LEDS/T_BIT/T0H/T1H/RESET_CYCLES combination");
   end

   ws2812_state_t    state_r, next_state_s;
   logic [GRB_W-1:0] pix_mem_r [NUM_LEDS];
   logic [GRB_W-1:0] sr_r, sr_next_s;
   logic [4:0]       bit_idx_r, bit_idx_next_s;
   logic [AW-1:0]    pix_idx_r, pix_idx_next_s, pix_inc_s;
   logic [CNT_W-1:0] gap_cnt_r;
   logic             first_gap_r;
   logic             ready_r, frame_done_r;
   logic             ready_s, frame_done_s;
   logic             wr_accept_s, start_req_s, sending_s, last_bit_s;
   logic             enc_start_s, enc_bit_s, enc_data_s, bit_done_s;

   assign wr_accept_s = wr_en && ({1'b0, wr_addr} < NUM_LEDS_C);
   assign sending_s   = (state_r == ST_HIGH) || (state_r == ST_LOW);
   assign last_bit_s  = (bit_idx_r == 5'd0) && (pix_idx_r == LAST_PIX_C);
   assign pix_inc_s   = pix_idx_r + {{(AW-1){1'b0}}, 1'b1};

`ifdef WS2812_AUTO_REFRESH_EN
   logic dirty_r;
   assign start_req_s = go || dirty_r;

   // Dirty flag: a write always wins over the clear so no update is lost
   always_ff @(posedge clk) begin
      if (reset) begin
         dirty_r <= 1'b0;
      end else if (wr_accept_s) begin
         dirty_r <= 1'b1;
      end else if ((state_r == ST_IDLE) && start_req_s) begin
         dirty_r <= 1'b0;
      end else begin
         dirty_r <= dirty_r;
      end
   end
`else
   assign start_req_s = go;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_GAP;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; HIGH/LOW follow the encoder's pin level
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_GAP:  next_state_s = (gap_cnt_r == GAP_LAST_C) ? ST_IDLE : ST_GAP;
         ST_IDLE: next_state_s = start_req_s ? ST_HIGH : ST_IDLE;
         ST_HIGH, ST_LOW: begin
            if (bit_done_s) begin
               next_state_s = last_bit_s ? ST_GAP : ST_HIGH;
            end else begin
               next_state_s = enc_data_s ? ST_HIGH : ST_LOW;
            end
         end
         default: next_state_s = ST_GAP;
      endcase
   end

   // Output decode, registered below so ready and frame_done change on the state edge
   always_comb begin
      ready_s      = (next_state_s == ST_IDLE);
      frame_done_s = (state_r == ST_GAP) && (next_state_s == ST_IDLE) && !first_gap_r;
   end

   // Registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         ready_r      <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         ready_r      <= ready_s;
         frame_done_r <= frame_done_s;
      end
   end

   // Shift register / index sequencing and the bit handed to the encoder
   always_comb begin
      sr_next_s      = sr_r;
      bit_idx_next_s = bit_idx_r;
      pix_idx_next_s = pix_idx_r;
      enc_start_s    = 1'b0;
      if ((state_r == ST_IDLE) && start_req_s) begin
         sr_next_s      = pix_mem_r[0];
         bit_idx_next_s = 5'd23;
         pix_idx_next_s = {AW{1'b0}};
         enc_start_s    = 1'b1;
      end else if (sending_s && bit_done_s) begin
         if (bit_idx_r != 5'd0) begin
            sr_next_s      = {sr_r[GRB_W-2:0], 1'b0};
            bit_idx_next_s = bit_idx_r - 5'd1;
            enc_start_s    = 1'b1;
         end else if (pix_idx_r < LAST_PIX_C) begin
            sr_next_s      = pix_mem_r[pix_inc_s];
            bit_idx_next_s = 5'd23;
            pix_idx_next_s = pix_inc_s;
            enc_start_s    = 1'b1;
         end else begin
            enc_start_s    = 1'b0;
         end
      end else begin
         enc_start_s = 1'b0;
      end
      enc_bit_s = sr_next_s[GRB_W-1];
   end

   // Datapath registers, latch-gap counter and pixel memory
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_r        <= {GRB_W{1'b0}};
         bit_idx_r   <= 5'd0;
         pix_idx_r   <= {AW{1'b0}};
         gap_cnt_r   <= {CNT_W{1'b0}};
         first_gap_r <= 1'b1;
         for (int i = 0; i < NUM_LEDS; i++) begin
            pix_mem_r[i] <= {GRB_W{1'b0}};
         end
      end else begin
         sr_r      <= sr_next_s;
         bit_idx_r <= bit_idx_next_s;
         pix_idx_r <= pix_idx_next_s;
         if ((state_r == ST_GAP) && (gap_cnt_r != GAP_LAST_C)) begin
            gap_cnt_r <= gap_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            gap_cnt_r <= {CNT_W{1'b0}};
         end
         if ((state_r == ST_GAP) && (next_state_s == ST_IDLE)) begin
            first_gap_r <= 1'b0;
         end else begin
            first_gap_r <= first_gap_r;
         end
         if (wr_accept_s) begin
            pix_mem_r[wr_addr] <= wr_grb;
         end else begin
            pix_mem_r[wr_addr] <= pix_mem_r[wr_addr];
         end
      end
   end

   ws2812_bit_encoder #(
      .T_BIT (T_BIT),
      .T0H   (T0H),
      .T1H   (T1H),
      .CNT_W (CNT_W)
   ) u_enc (
      .clk      (clk),
      .reset    (reset),
      .start    (enc_start_s),
      .bit_in   (enc_bit_s),
      .data_out (enc_data_s),
      .bit_done (bit_done_s)
   );

   assign data_out   = enc_data_s;
   assign ready      = ready_r;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_ws2812_frame_sender.sv
// Scoreboard bench: stimulus queues expected bits and frame lengths, a negedge monitor decodes the pin.
module tb_ws2812_frame_sender;

   localparam int NUM_LEDS     = 2;
   localparam int T_BIT        = 10;
   localparam int T0H          = 3;
   localparam int T1H          = 7;
   localparam int RESET_CYCLES = 50;
   localparam int FRAME_LEN    = 530;   // 48 bits * 10 cycles + 50 gap, from first rise to frame_done

   logic        clk = 1'b0;
   logic        reset, wr_en, go;
   logic [0:0]  wr_addr;
   logic [23:0] wr_grb;
   logic        data_out, ready, frame_done;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic mon_en = 1'b0;
   logic exp_bits[$];
   int   exp_done[$];

   int   hi_len = 0;
   logic prev_d = 1'b0;
   logic in_frame = 1'b0;
   int   frame_start = 0;
   int   last_rise = 0;

   ws2812_frame_sender #(
      .NUM_LEDS(NUM_LEDS), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .RESET_CYCLES(RESET_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_grb(wr_grb),
      .go(go), .data_out(data_out), .ready(ready), .frame_done(frame_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_pix(input logic [0:0] a, input logic [23:0] v);
      wr_en = 1'b1; wr_addr = a; wr_grb = v;
      step();
      wr_en = 1'b0;
   endtask

   task automatic pulse_go();
      go = 1'b1;
      step();
      go = 1'b0;
   endtask

   task automatic push_frame(input logic [23:0] p0, input logic [23:0] p1);
      for (int i = 23; i >= 0; i--) exp_bits.push_back(p0[i]);
      for (int i = 23; i >= 0; i--) exp_bits.push_back(p1[i]);
      exp_done.push_back(FRAME_LEN);
   endtask

   task automatic wait_done();
      int n = 0;
      while (frame_done !== 1'b1 && n < 1000) begin
         step();
         n++;
      end
      chk("frame_done_seen", frame_done, 1);
   endtask

   task automatic wait_ready(output int n, output logic saw);
      n = 0; saw = 1'b0;
      while (ready !== 1'b1 && n < 500) begin
         step();
         n++;
         if (data_out === 1'b1) saw = 1'b1;
      end
   endtask

   // Monitor: decodes pulse widths and periods, checks frame length at every frame_done
   initial begin
      logic eb;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            hi_len = 0; prev_d = 1'b0; in_frame = 1'b0;
         end else begin
            if (data_out === 1'b1) hi_len++;
            if (prev_d && data_out !== 1'b1) begin
               if (exp_bits.size() == 0) begin
                  chk("unexpected_pulse", hi_len, 0);
               end else begin
                  eb = exp_bits.pop_front();
                  chk("bit_high_width", hi_len, eb ? T1H : T0H);
               end
               hi_len = 0;
            end
            if (!prev_d && data_out === 1'b1) begin
               if (in_frame) chk("bit_period", cyc - last_rise, T_BIT);
               else frame_start = cyc;
               last_rise = cyc;
               in_frame = 1'b1;
            end
            prev_d = (data_out === 1'b1);
         end
         if (frame_done === 1'b1) begin
            if (exp_done.size() == 0) begin
               chk("unexpected_frame_done", 1, 0);
            end else begin
               chk("frame_length", cyc - frame_start, exp_done.pop_front());
               chk("ready_with_done", ready, 1);
            end
            in_frame = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      logic saw;
      reset = 1'b1; go = 1'b0; wr_en = 1'b0; wr_addr = 1'b0; wr_grb = 24'h0;
      repeat (3) step();
      chk("reset_data_out", data_out, 0);
      chk("reset_ready", ready, 0);
      chk("reset_frame_done", frame_done, 0);
      reset = 1'b0;
      mon_en = 1'b1;
      wait_ready(n, saw);
      chk("ready_after_reset", n, 50);
      chk("idle_data_low", saw, 0);

`ifdef WS2812_AUTO_REFRESH_EN
      push_frame(24'h112233, 24'h000000);
      write_pix(1'b0, 24'h112233);
      chk("auto_not_yet", data_out, 0);
      step();
      chk("auto_start", data_out, 1);
      wait_done();
`else
      // Frame A: basic pattern
      write_pix(1'b0, 24'hA50000);
      write_pix(1'b1, 24'h0000FF);
      push_frame(24'hA50000, 24'h0000FF);
      pulse_go();
      chk("go_data_high", data_out, 1);
      chk("go_ready_low", ready, 0);
      wait_done();

      // Frame B: ignored second go, writes ahead of and behind the load point
      push_frame(24'hA50000, 24'h3C5A81);
      pulse_go();
      repeat (3) step();
      pulse_go();
      repeat (90) step();
      write_pix(1'b1, 24'h3C5A81);
      repeat (200) step();
      write_pix(1'b0, 24'h00FF00);
      wait_done();

      // Frame C: the late pixel-0 write shows up now
      push_frame(24'h00FF00, 24'h3C5A81);
      pulse_go();
      wait_done();

      // Frame D: reset at cycle 100 abandons the frame
      mon_en = 1'b0;
      pulse_go();
      repeat (99) step();
      reset = 1'b1;
      step();
      chk("midreset_data_out", data_out, 0);
      chk("midreset_ready", ready, 0);
      step();
      reset = 1'b0;
      wait_ready(n, saw);
      chk("ready_after_midreset", n, 50);
      chk("midreset_gap_low", saw, 0);
      mon_en = 1'b1;

      // No auto refresh in this build: a write alone sends nothing
      write_pix(1'b0, 24'h112233);
      saw = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (data_out === 1'b1) saw = 1'b1;
      end
      chk("no_auto_refresh", saw, 0);
      chk("idle_ready_stays", ready, 1);
`endif

      repeat (5) step();
      chk("bits_left", exp_bits.size(), 0);
      chk("frames_left", exp_done.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
